// File: rtl/synth_pkg.sv
// Shared types and helpers for the polyphonic oscillator bank.
package synth_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SINE   = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Mix width large enough that summing every voice at full scale cannot overflow.
    function automatic int mix_width(int sample_w, int level_w, int num_voices);
        return sample_w + level_w + $clog2(num_voices);
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM, contents computed at elaboration, one-cycle registered read.
module sine_quarter_lut #(
    parameter int SAMPLE_W = 12,
    parameter int LUT_AW   = 6
) (
    input  logic                clk,
    input  logic [LUT_AW-1:0]   addr,
    output logic [SAMPLE_W-2:0] data
);

    localparam int  DEPTH = 1 << LUT_AW;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = real'((1 << (SAMPLE_W - 1)) - 1);

    // Half-step offset keeps the quarter symmetric so address inversion mirrors it exactly.
    function automatic int entry(int k);
        real x;
        x = AMP * $sin((real'(k) + 0.5) * PI / real'(2 * DEPTH));
        return $rtoi(x + 0.5);
    endfunction

    logic [SAMPLE_W-2:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int VAL = entry(k);
        assign rom[k] = VAL[SAMPLE_W-2:0];
    end

    always_ff @(posedge clk) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/poly_oscillator_bank.sv
// Time-multiplexed DDS oscillator bank: walks every voice through one shared
// waveform/envelope/MAC datapath per sample tick and emits one mixed sample.
module poly_oscillator_bank
    import synth_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int PHASE_W      = 24,
    parameter int SAMPLE_W     = 12,
    parameter int LEVEL_W      = 8,
    parameter int LUT_AW       = 6,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 2,
    localparam int VOICE_W     = $clog2(NUM_VOICES),
    localparam int MIX_W       = mix_width(SAMPLE_W, LEVEL_W, NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [VOICE_W-1:0]    cfg_voice,
    input  logic [PHASE_W-1:0]    cfg_phase_inc,
    input  logic [1:0]            cfg_wave,
    input  logic [3:0]            cfg_gain,
    input  logic                  cfg_gate,
    input  logic                  sample_tick,
    output logic                  busy,
    output logic                  sample_valid,
    output logic [MIX_W-1:0]      mix_out,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  overrun
);

    localparam logic [VOICE_W-1:0]         LAST_VOICE = VOICE_W'(NUM_VOICES - 1);
    localparam logic [LEVEL_W-1:0]         ATK        = LEVEL_W'(ATTACK_STEP);
    localparam logic [LEVEL_W-1:0]         REL        = LEVEL_W'(RELEASE_STEP);
    localparam logic signed [SAMPLE_W-1:0] FULL_POS   = SAMPLE_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [SAMPLE_W-1:0] FULL_NEG   = -FULL_POS;

    logic [PHASE_W-1:0] phase_r [NUM_VOICES];
    logic [PHASE_W-1:0] inc_r   [NUM_VOICES];
    wave_e              wave_r  [NUM_VOICES];
    logic [3:0]         gain_r  [NUM_VOICES];
    logic               gate_r  [NUM_VOICES];
    logic [LEVEL_W-1:0] level_r [NUM_VOICES];

    state_e             state;
    logic [VOICE_W-1:0] idx;
    logic               drain_cnt;

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_active[v] = gate_r[v] | (level_r[v] != '0);
        end
    end

    // Stage 0: read the voice addressed by the counter (pre-update values).
    logic [PHASE_W-1:0]  cur_phase;
    logic [LEVEL_W-1:0]  cur_level, cur_target, next_level;
    wave_e               cur_wave;
    logic                cur_active;
    logic [SAMPLE_W-1:0] cur_s, direct_sample;
    logic [SAMPLE_W-2:0] tri_q;
    logic [LUT_AW-1:0]   lut_addr;

    assign cur_phase  = phase_r[idx];
    assign cur_level  = level_r[idx];
    assign cur_wave   = wave_r[idx];
    assign cur_active = voice_active[idx];
    assign cur_target = LEVEL_W'(gain_r[idx]) << (LEVEL_W - 4);
    assign cur_s      = cur_phase[PHASE_W-1 -: SAMPLE_W];
    assign lut_addr   = cur_phase[PHASE_W-3 -: LUT_AW] ^ {LUT_AW{cur_phase[PHASE_W-2]}};

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        direct_sample = '0;
        tri_q         = cur_s[SAMPLE_W-2:0] ^ {(SAMPLE_W - 1){cur_phase[PHASE_W-1]}};
        unique case (cur_wave)
            WAVE_SQUARE: direct_sample = cur_phase[PHASE_W-1] ? FULL_NEG : FULL_POS;
            WAVE_SAW:    direct_sample = {~cur_s[SAMPLE_W-1], cur_s[SAMPLE_W-2:0]};
            WAVE_TRI:    direct_sample = {~tri_q[SAMPLE_W-2], tri_q[SAMPLE_W-3:0], 1'b0};
            default:     direct_sample = '0;
        endcase
    end

    // Envelope steps compare distances first so level never wraps past 0 or the target.
    always_comb begin
        next_level = cur_level;
        if (gate_r[idx]) begin
            if (cur_level > cur_target) begin
                next_level = (cur_level - cur_target > REL) ? cur_level - REL : cur_target;
            end else begin
                next_level = (cur_target - cur_level > ATK) ? cur_level + ATK : cur_target;
            end
        end else begin
            next_level = (cur_level > REL) ? cur_level - REL : '0;
        end
    end

    logic cfg_ok, cfg_hit, wb_en;
    assign cfg_ok  = cfg_we && ({1'b0, cfg_voice} < (VOICE_W + 1)'(NUM_VOICES));
    assign cfg_hit = cfg_ok && (cfg_voice == idx);
    assign wb_en   = (state == RUN) && cur_active && !cfg_hit;

    // NOTE: voice state lives in flops rather than RAM, so the whole array can take the reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_r[v] <= '0;
                inc_r[v]   <= '0;
                wave_r[v]  <= WAVE_SQUARE;
                gain_r[v]  <= '0;
                gate_r[v]  <= 1'b0;
                level_r[v] <= '0;
            end
        end else begin
            if (wb_en) begin
                phase_r[idx] <= cur_phase + inc_r[idx];
                level_r[idx] <= next_level;
            end
            if (cfg_ok) begin
                inc_r[cfg_voice]  <= cfg_phase_inc;
                wave_r[cfg_voice] <= wave_e'(cfg_wave);
                gain_r[cfg_voice] <= cfg_gain;
                gate_r[cfg_voice] <= cfg_gate;
                if (cfg_gate && !gate_r[cfg_voice]) begin
                    phase_r[cfg_voice] <= '0;
                    level_r[cfg_voice] <= '0;
                end
            end
        end
    end

    // Stage 1: waveform and LUT output registered together.
    logic [SAMPLE_W-2:0]        lut_data;
    logic                       s1_valid, s1_neg;
    wave_e                      s1_wave;
    logic [SAMPLE_W-1:0]        s1_direct;
    logic [LEVEL_W-1:0]         s1_level;

    sine_quarter_lut #(
        .SAMPLE_W (SAMPLE_W),
        .LUT_AW   (LUT_AW)
    ) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .data (lut_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_neg    <= 1'b0;
            s1_wave   <= WAVE_SQUARE;
            s1_direct <= '0;
            s1_level  <= '0;
        end else begin
            s1_valid  <= (state == RUN);
            s1_neg    <= cur_phase[PHASE_W-1];
            s1_wave   <= cur_wave;
            s1_direct <= direct_sample;
            s1_level  <= cur_level;
        end
    end

    // Stage 2: scale by envelope and accumulate.
    logic signed [SAMPLE_W-1:0] lut_signed, sample;
    logic signed [MIX_W-1:0]    sample_ext, level_ext, product, acc;

    always_comb begin
        lut_signed = $signed({1'b0, lut_data});
        sample     = $signed(s1_direct);
        if (s1_wave == WAVE_SINE) begin
            sample = s1_neg ? -lut_signed : lut_signed;
        end
        sample_ext = MIX_W'(sample);
        level_ext  = $signed(MIX_W'({1'b0, s1_level}));
        product    = sample_ext * level_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (state == IDLE && sample_tick) begin
            acc <= '0;
        end else if (s1_valid) begin
            acc <= acc + product;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            drain_cnt    <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            mix_out      <= '0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (sample_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state <= RUN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (idx == LAST_VOICE) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        sample_valid <= 1'b1;
                        mix_out      <= acc;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_oscillator_bank.sv
// Directed bench for poly_oscillator_bank: frame tables plus hand-timed corner cases.
module tb_poly_oscillator_bank;
    import synth_pkg::*;

    localparam int N       = 4;
    localparam int PHASE_W = 24;
    localparam int MIX_W   = 22;
    localparam int LAT     = N + 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_voice = '0;
    logic [PHASE_W-1:0] cfg_phase_inc = '0;
    logic [1:0]         cfg_wave = '0;
    logic [3:0]         cfg_gain = '0;
    logic               cfg_gate = 1'b0;
    logic               sample_tick = 1'b0;
    logic               busy, sample_valid, overrun;
    logic [MIX_W-1:0]   mix_out;
    logic [N-1:0]       voice_active;

    poly_oscillator_bank #(
        .NUM_VOICES   (N),
        .PHASE_W      (PHASE_W),
        .SAMPLE_W     (12),
        .LEVEL_W      (8),
        .LUT_AW       (6),
        .ATTACK_STEP  (4),
        .RELEASE_STEP (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_voice     (cfg_voice),
        .cfg_phase_inc (cfg_phase_inc),
        .cfg_wave      (cfg_wave),
        .cfg_gain      (cfg_gain),
        .cfg_gate      (cfg_gate),
        .sample_tick   (sample_tick),
        .busy          (busy),
        .sample_valid  (sample_valid),
        .mix_out       (mix_out),
        .voice_active  (voice_active),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              name;
        logic               cfg;
        logic [1:0]         voice;
        logic [PHASE_W-1:0] inc;
        logic [1:0]         wave;
        logic [3:0]         gain;
        logic               gate;
        int                 exp_mix;
        logic [N-1:0]       exp_active;
    } vec_t;

    vec_t vecs[$];
    int   got[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(string name, logic cfg, logic [1:0] voice, logic [PHASE_W-1:0] inc,
                                logic [1:0] wave, logic [3:0] gain, logic gate, int exp_mix,
                                logic [N-1:0] exp_active);
        vec_t v;
        v.name = name; v.cfg = cfg; v.voice = voice; v.inc = inc; v.wave = wave;
        v.gain = gain; v.gate = gate; v.exp_mix = exp_mix; v.exp_active = exp_active;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lut_entry(int k);
        return $rtoi(2047.0 * $sin((real'(k) + 0.5) * 3.14159265358979 / 128.0) + 0.5);
    endfunction

    function automatic int sine_model(int p);
        int k, v;
        k = (p >> 16) & 63;
        if (((p >> 22) & 1) == 1) k = 63 - k;
        v = lut_entry(k);
        if (((p >> 23) & 1) == 1) v = -v;
        return v;
    endfunction

    task automatic do_cfg(input logic [1:0] voice, input logic [PHASE_W-1:0] inc,
                          input logic [1:0] wave, input logic [3:0] gain, input logic gate);
        @(negedge clk);
        cfg_we = 1'b1; cfg_voice = voice; cfg_phase_inc = inc;
        cfg_wave = wave; cfg_gain = gain; cfg_gate = gate;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One frame: tick in cycle t, observe cycles t+1..t+16. act 1 = cfg write to voice 1,
    // 2 = extra tick, 3 = reset, applied in cycle t+act_at.
    task automatic run_frame(input int act_at, input int act, output int mix, output int lat,
                             output logic [31:0] busy_tr, output int n_valid);
        @(negedge clk);
        sample_tick = 1'b1;
        lat = -1; mix = 0; busy_tr = '0; n_valid = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            sample_tick = 1'b0; cfg_we = 1'b0; reset = 1'b0;
            if (k == act_at) begin
                case (act)
                    1: begin
                        cfg_we = 1'b1; cfg_voice = 2'd1; cfg_phase_inc = '0;
                        cfg_wave = WAVE_SQUARE; cfg_gain = 4'd15; cfg_gate = 1'b1;
                    end
                    2: sample_tick = 1'b1;
                    3: reset = 1'b1;
                    default: ;
                endcase
            end
            busy_tr[k] = busy;
            if (sample_valid) begin
                n_valid++;
                if (lat < 0) begin
                    lat = k;
                    mix = int'($signed(mix_out));
                end
            end
        end
    endtask

    task automatic ramp(input int n);
        int m, l, nv;
        logic [31:0] b;
        repeat (n) run_frame(0, 0, m, l, b, nv);
    endtask

    task automatic apply_table();
        int m, l, nv;
        logic [31:0] b;
        got.delete();
        foreach (vecs[i]) begin
            if (vecs[i].cfg) do_cfg(vecs[i].voice, vecs[i].inc, vecs[i].wave, vecs[i].gain, vecs[i].gate);
            run_frame(0, 0, m, l, b, nv);
            got.push_back(m);
            check({vecs[i].name, "_mix"}, m, vecs[i].exp_mix);
            check({vecs[i].name, "_lat"}, l, LAT);
            check({vecs[i].name, "_active"}, int'(voice_active), int'(vecs[i].exp_active));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int m, l, nv;
        logic [31:0] b;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mix", int'(mix_out), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_active", int'(voice_active), 0);

        // Idle frame: latency, busy window, single-cycle valid.
        run_frame(0, 0, m, l, b, nv);
        check("idle_lat", l, LAT);
        check("idle_mix", m, 0);
        check("idle_busy_first", int'(b[1]), 1);
        check("idle_busy_last", int'(b[N+2]), 1);
        check("idle_busy_done", int'(b[N+3]), 0);
        check("idle_valid_pulses", nv, 1);

        // Square on voice 0, quarter-cycle increment, attack ramp.
        vecs.delete();
        vecs.push_back(mk("sq_f1", 1, 0, 24'h400000, WAVE_SQUARE, 15, 1, 0, 4'b0001));
        vecs.push_back(mk("sq_f2", 0, 0, 0, 0, 0, 0, 8188, 4'b0001));
        vecs.push_back(mk("sq_f3", 0, 0, 0, 0, 0, 0, -16376, 4'b0001));
        vecs.push_back(mk("sq_f4", 0, 0, 0, 0, 0, 0, -24564, 4'b0001));
        vecs.push_back(mk("sq_f5", 0, 0, 0, 0, 0, 0, 32752, 4'b0001));
        vecs.push_back(mk("sq_f6", 0, 0, 0, 0, 0, 0, 40940, 4'b0001));
        vecs.push_back(mk("sq_f7", 0, 0, 0, 0, 0, 0, -49128, 4'b0001));
        vecs.push_back(mk("sq_f8", 0, 0, 0, 0, 0, 0, -57316, 4'b0001));
        apply_table();

        ramp(52);
        run_frame(0, 0, m, l, b, nv);
        check("sq_f61_cap", m, 491280);
        run_frame(0, 0, m, l, b, nv);
        check("sq_f62_cap", m, 491280);

        // Release from 240 at 2 per frame.
        do_cfg(0, 24'h400000, WAVE_SQUARE, 15, 0);
        run_frame(0, 0, m, l, b, nv);
        check("rel_f63", m, -491280);
        ramp(117);
        run_frame(0, 0, m, l, b, nv);
        check("rel_f181", m, 8188);
        check("rel_f181_active", int'(voice_active), 1);
        run_frame(0, 0, m, l, b, nv);
        check("rel_f182", m, 4094);
        check("rel_f182_active", int'(voice_active), 0);
        run_frame(0, 0, m, l, b, nv);
        check("rel_f183", m, 0);

        // Sine on voice 2: ramp at fixed phase 0, then eighth-cycle increment.
        do_cfg(2, 24'h0, WAVE_SINE, 15, 1);
        ramp(60);
        vecs.delete();
        for (int j = 0; j < 9; j++) begin
            int p;
            p = (j << 21) & 32'h00FF_FFFF;
            vecs.push_back(mk($sformatf("sine_f%0d", j), (j == 0), 2, 24'h200000, WAVE_SINE, 15, 1,
                              240 * sine_model(p), 4'b0100));
        end
        apply_table();
        check("sine_peak", got[2], 491280);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("sine_sym%0d", j), got[j + 4], -got[j]);
        end

        // All four voices saw at phase 0, full level.
        do_cfg(2, 24'h0, WAVE_SINE, 15, 0);
        for (int v = 0; v < N; v++) do_cfg(2'(v), 24'h0, WAVE_SAW, 15, 1);
        run_frame(0, 0, m, l, b, nv);
        check("saw_f1", m, 0);
        run_frame(0, 0, m, l, b, nv);
        check("saw_f2", m, -32768);
        check("saw_f2_active", int'(voice_active), 15);
        ramp(58);
        run_frame(0, 0, m, l, b, nv);
        check("saw_full", m, -1966080);

        // Config write to voice 1 in its read cycle: old wave this frame, new next.
        run_frame(2, 1, m, l, b, nv);
        check("cfgrace_now", m, -1966080);
        check("cfgrace_lat", l, LAT);
        run_frame(0, 0, m, l, b, nv);
        check("cfgrace_next", m, -983280);

        // Tick while busy is ignored and sets sticky overrun.
        check("ovr_before", int'(overrun), 0);
        run_frame(2, 2, m, l, b, nv);
        check("ovr_lat", l, LAT);
        check("ovr_mix", m, -983280);
        check("ovr_valid_pulses", nv, 1);
        check("ovr_flag", int'(overrun), 1);
        run_frame(0, 0, m, l, b, nv);
        check("ovr_sticky", int'(overrun), 1);

        // Reset mid-frame: no valid, everything cleared.
        run_frame(3, 3, m, l, b, nv);
        check("mrst_valid_pulses", nv, 0);
        check("mrst_mix", int'(mix_out), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_overrun", int'(overrun), 0);
        check("mrst_active", int'(voice_active), 0);
        run_frame(0, 0, m, l, b, nv);
        check("mrst_next_lat", l, LAT);
        check("mrst_next_mix", m, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
